elevator_car_ctrl: RTL and testbench
====================================

Name: elevator_car_ctrl

Overview:
- Downstream execution stage of the elevator control FSM. Consumes the 2-bit state code (q1, q0) and the error flag produced by the control FSM.
- Drives the motor up/down and door outputs, and tracks the current floor with a per-floor travel counter.
- Times the door-open interval and returns floor/door status (at_target, door_done) to the control logic.

Parameters:
- NUM_FLOORS, 8, number of floors, numbered 0..NUM_FLOORS-1; legal range 2..16.
- FLOOR_W, 3, width of floor buses; must satisfy 2^FLOOR_W >= NUM_FLOORS.
- TRAVEL_CYCLES, 4, clock cycles of motion per floor step; must be >= 1.
- DOOR_CYCLES, 8, clock cycles the door stays open; must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- q1  in  1  state code MSB from the control FSM.
- q0  in  1  state code LSB from the control FSM.
- erro  in  1  error flag from the control FSM.
- target_floor  in  FLOOR_W  requested destination floor.
- fault_clr  in  1  synchronous clear of the latched fault.
- floor  out  FLOOR_W  current car floor.
- at_target  out  1  high when floor == target_floor and the car is not moving.
- motor_up  out  1  motor drive, upward.
- motor_down  out  1  motor drive, downward.
- door_open  out  1  door actuator.
- door_done  out  1  one-cycle pulse when the door interval expires.
- limit_err  out  1  one-cycle pulse when a move past the top or bottom floor is requested.
- fault  out  1  sticky fault indicator.

Behaviour:
- Reset (asynchronous):
  - floor = 0; all counters = 0; FSM in IDLE.
  - All outputs 0, except at_target, which follows its combinational definition (1 if target_floor == 0).
- State code {q1,q0}: 00 = stop, 01 = up, 10 = down, 11 = door.
- The code is sampled every cycle. All outputs are registered except at_target, which is combinational from floor, target_floor and the FSM state.
- FSM states are IDLE, MOVE, DOOR, FAULT.
- IDLE:
  - All drive outputs 0.
  - Code 01 with floor < NUM_FLOORS-1, or code 10 with floor > 0: go to MOVE; travel counter = 0; assert the matching motor output from the next cycle.
  - Code 01 at the top floor, or code 10 at floor 0: stay in IDLE and pulse limit_err for one cycle.
  - Code 11: go to DOOR; door counter = 0; door_open = 1.
- MOVE:
  - Travel counter increments every cycle.
  - When it reaches TRAVEL_CYCLES-1: floor steps by ±1, counter clears, and the FSM returns to IDLE. The motor output drops in the same edge.
  - Latency from code to floor change is TRAVEL_CYCLES+1 edges.
  - A code change mid-step is ignored; the step always completes. The floor never wraps.
- DOOR:
  - door_open = 1 and the door counter increments every cycle.
  - When it reaches DOOR_CYCLES-1: pulse door_done for one cycle, clear door_open, return to IDLE.
  - The code is ignored while in DOOR.
- FAULT:
  - erro = 1 in any state moves the FSM to FAULT on the next edge. erro has priority over every other input.
  - In FAULT: motor_up = motor_down = 0, door_open = 1, fault = 1.
  - A step interrupted by the fault is abandoned and floor is unchanged.
  - Exit only via rst, or via fault_clr = 1 while erro = 0, which goes to IDLE.
  - fault_clr while erro = 1 has no effect.
- Invariant: motor_up and motor_down are never both 1; motor outputs are never 1 while door_open = 1.

Optional Feature:
- Macro FLOOR_7SEG_EN.
- Defined: adds output seg_n [6:0], a registered active-low 7-segment hex decode of floor (segments a..g = bits 0..6). It shows "E" (seg_n = 7'b0000110) while fault = 1. Reset value is the "0" pattern, 7'b1000000.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst with target_floor = 0 -> floor = 0, every registered output = 0, at_target = 1, FSM IDLE.
- Move up, one floor: floor 0, code 01 held one cycle -> motor_up high for 4 cycles, floor = 1 on the 5th edge, at_target = 1 when target_floor = 1.
- Bottom limit: floor 0, code 10 -> limit_err single pulse, motors stay 0, floor stays 0.
- Top limit: step the car to floor 7, then code 01 -> limit_err single pulse, floor stays 7.
- Door cycle: code 11 -> door_open high for exactly 8 cycles, door_done pulses on the edge door_open falls; code 01 asserted mid-door is ignored.
- Fault: erro = 1 during cycle 2 of a MOVE step -> motor off next edge, floor unchanged, fault = 1, door_open = 1. fault_clr with erro = 1 -> no change. fault_clr with erro = 0 -> IDLE, fault = 0. With FLOOR_7SEG_EN, seg_n = 7'b0000110 while faulted.

Source files
------------

// File: rtl/elevator_car_ctrl_if.sv
// rtl/elevator_car_ctrl_if.sv - control-FSM to car-stage bundle (seg_n present only with FLOOR_7SEG_EN)
interface elevator_car_ctrl_if #(
   parameter int FLOOR_W = 3
);
   logic               q1;
   logic               q0;
   logic               erro;
   logic [FLOOR_W-1:0] target_floor;
   logic               fault_clr;
   logic [FLOOR_W-1:0] floor;
   logic               at_target;
   logic               motor_up;
   logic               motor_down;
   logic               door_open;
   logic               door_done;
   logic               limit_err;
   logic               fault;
`ifdef FLOOR_7SEG_EN
   logic [6:0]         seg_n;
`endif

   modport master (
      output q1, q0, erro, target_floor, fault_clr,
      input  floor, at_target, motor_up, motor_down, door_open, door_done, limit_err, fault
`ifdef FLOOR_7SEG_EN
      , input seg_n
`endif
   );

   modport slave (
      input  q1, q0, erro, target_floor, fault_clr,
      output floor, at_target, motor_up, motor_down, door_open, door_done, limit_err, fault
`ifdef FLOOR_7SEG_EN
      , output seg_n
`endif
   );
endinterface

// File: rtl/elevator_car_ctrl.sv
// rtl/elevator_car_ctrl.sv - car execution stage: motor/door drive, floor tracking, fault latch
// Optional FLOOR_7SEG_EN adds a registered active-low 7-segment floor display (seg_n).
module elevator_car_ctrl #(
   parameter int NUM_FLOORS    = 8,
   parameter int FLOOR_W       = 3,
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 8
) (
   input logic               clk,
   input logic               rst,
   elevator_car_ctrl_if.slave bus
);
   localparam int TCW = $clog2(TRAVEL_CYCLES + 1);
   localparam int DCW = $clog2(DOOR_CYCLES + 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
   localparam logic [TCW-1:0] TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
   localparam logic [DCW-1:0] DOOR_LAST = DCW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, MOVE, DOOR, FAULT} state_t;

   state_t         state;
   logic [TCW-1:0] travel_cnt;
   logic [DCW-1:0] door_cnt;
   logic           dir_up;
   logic [1:0]     code;

   assign code = {bus.q1, bus.q0};
   assign bus.at_target = (bus.floor == bus.target_floor) && (state != MOVE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         travel_cnt     <= '0;
         door_cnt       <= '0;
         dir_up         <= 1'b0;
         bus.floor      <= '0;
         bus.motor_up   <= 1'b0;
         bus.motor_down <= 1'b0;
         bus.door_open  <= 1'b0;
         bus.door_done  <= 1'b0;
         bus.limit_err  <= 1'b0;
         bus.fault      <= 1'b0;
      end else begin
         bus.door_done <= 1'b0;
         bus.limit_err <= 1'b0;
         // erro overrides everything; an in-flight step is dropped without touching floor
         if (bus.erro) begin
            state          <= FAULT;
            travel_cnt     <= '0;
            door_cnt       <= '0;
            bus.motor_up   <= 1'b0;
            bus.motor_down <= 1'b0;
            bus.door_open  <= 1'b1;
            bus.fault      <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  case (code)
                     2'b01: begin
                        if (bus.floor < TOP_FLOOR) begin
                           state        <= MOVE;
                           travel_cnt   <= '0;
                           dir_up       <= 1'b1;
                           bus.motor_up <= 1'b1;
                        end else begin
                           bus.limit_err <= 1'b1;
                        end
                     end
                     2'b10: begin
                        if (bus.floor != '0) begin
                           state          <= MOVE;
                           travel_cnt     <= '0;
                           dir_up         <= 1'b0;
                           bus.motor_down <= 1'b1;
                        end else begin
                           bus.limit_err <= 1'b1;
                        end
                     end
                     2'b11: begin
                        state         <= DOOR;
                        door_cnt      <= '0;
                        bus.door_open <= 1'b1;
                     end
                     default: ;
                  endcase
               end
               MOVE: begin
                  if (travel_cnt == TRAVEL_LAST) begin
                     bus.floor      <= dir_up ? bus.floor + FLOOR_W'(1) : bus.floor - FLOOR_W'(1);
                     travel_cnt     <= '0;
                     bus.motor_up   <= 1'b0;
                     bus.motor_down <= 1'b0;
                     state          <= IDLE;
                  end else begin
                     travel_cnt <= travel_cnt + TCW'(1);
                  end
               end
               DOOR: begin
                  if (door_cnt == DOOR_LAST) begin
                     door_cnt      <= '0;
                     bus.door_open <= 1'b0;
                     bus.door_done <= 1'b1;
                     state         <= IDLE;
                  end else begin
                     door_cnt <= door_cnt + DCW'(1);
                  end
               end
               FAULT: begin
                  if (bus.fault_clr) begin
                     state         <= IDLE;
                     bus.fault     <= 1'b0;
                     bus.door_open <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef FLOOR_7SEG_EN
   logic [3:0] floor_nib;
   assign floor_nib = 4'(bus.floor);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.seg_n <= 7'b1000000;
      end else if (bus.fault) begin
         bus.seg_n <= 7'b0000110;
      end else begin
         case (floor_nib)
            4'h0: bus.seg_n <= 7'b1000000;
            4'h1: bus.seg_n <= 7'b1111001;
            4'h2: bus.seg_n <= 7'b0100100;
            4'h3: bus.seg_n <= 7'b0110000;
            4'h4: bus.seg_n <= 7'b0011001;
            4'h5: bus.seg_n <= 7'b0010010;
            4'h6: bus.seg_n <= 7'b0000010;
            4'h7: bus.seg_n <= 7'b1111000;
            4'h8: bus.seg_n <= 7'b0000000;
            4'h9: bus.seg_n <= 7'b0010000;
            4'hA: bus.seg_n <= 7'b0001000;
            4'hB: bus.seg_n <= 7'b0000011;
            4'hC: bus.seg_n <= 7'b1000110;
            4'hD: bus.seg_n <= 7'b0100001;
            4'hE: bus.seg_n <= 7'b0000110;
            default: bus.seg_n <= 7'b0001110;
         endcase
      end
   end
`endif
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb/tb_elevator_car_ctrl.sv - directed self-checking bench for elevator_car_ctrl
module tb_elevator_car_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   elevator_car_ctrl_if #(.FLOOR_W(3)) bus ();

   elevator_car_ctrl #(
      .NUM_FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_code(input logic [1:0] c);
      bus.q1 = c[1];
      bus.q0 = c[0];
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      set_code(2'b00);
      bus.erro = 1'b0;
      bus.fault_clr = 1'b0;
      bus.target_floor = 3'd0;
      tick(2);

      // reset state
      chk("rst_floor", 32'(bus.floor), 0);
      chk("rst_motor_up", 32'(bus.motor_up), 0);
      chk("rst_motor_down", 32'(bus.motor_down), 0);
      chk("rst_door_open", 32'(bus.door_open), 0);
      chk("rst_door_done", 32'(bus.door_done), 0);
      chk("rst_limit_err", 32'(bus.limit_err), 0);
      chk("rst_fault", 32'(bus.fault), 0);
      chk("rst_at_target", 32'(bus.at_target), 1);
`ifdef FLOOR_7SEG_EN
      chk("rst_seg_n", 32'(bus.seg_n), 32'h40);
`endif
      rst = 1'b0;
      tick(1);

      // one floor up: motor_up for 4 cycles, floor changes on the 5th edge
      bus.target_floor = 3'd1;
      set_code(2'b01);
      tick(1);
      set_code(2'b00);
      chk("move_at_target_low", 32'(bus.at_target), 0);
      for (int i = 0; i < 4; i++) begin
         chk("move_motor_up", 32'(bus.motor_up), 1);
         chk("move_floor_hold", 32'(bus.floor), 0);
         tick(1);
      end
      chk("move_floor_1", 32'(bus.floor), 1);
      chk("move_motor_up_off", 32'(bus.motor_up), 0);
      chk("move_at_target", 32'(bus.at_target), 1);

      // back down to 0, then bottom limit
      set_code(2'b10);
      tick(1);
      set_code(2'b00);
      chk("down_motor_down", 32'(bus.motor_down), 1);
      tick(4);
      chk("down_floor_0", 32'(bus.floor), 0);
      set_code(2'b10);
      tick(1);
      set_code(2'b00);
      chk("bot_limit_err", 32'(bus.limit_err), 1);
      chk("bot_motor_down", 32'(bus.motor_down), 0);
      tick(1);
      chk("bot_limit_pulse", 32'(bus.limit_err), 0);
      chk("bot_floor", 32'(bus.floor), 0);

      // climb to the top floor, then top limit
      for (int f = 0; f < 7; f++) begin
         set_code(2'b01);
         tick(1);
         set_code(2'b00);
         tick(4);
      end
      bus.target_floor = 3'd7;
      chk("top_floor_7", 32'(bus.floor), 7);
      set_code(2'b01);
      tick(1);
      set_code(2'b00);
      chk("top_limit_err", 32'(bus.limit_err), 1);
      chk("top_motor_up", 32'(bus.motor_up), 0);
      tick(1);
      chk("top_limit_pulse", 32'(bus.limit_err), 0);
      chk("top_floor_hold", 32'(bus.floor), 7);
      chk("top_at_target", 32'(bus.at_target), 1);

      // door cycle with an up request that must be ignored
      set_code(2'b11);
      tick(1);
      set_code(2'b01);
      for (int i = 0; i < 8; i++) begin
         chk("door_open", 32'(bus.door_open), 1);
         chk("door_no_motor", 32'(bus.motor_up), 0);
         chk("door_done_low", 32'(bus.door_done), 0);
         if (i == 6) set_code(2'b00);
         tick(1);
      end
      chk("door_closed", 32'(bus.door_open), 0);
      chk("door_done_pulse", 32'(bus.door_done), 1);
      tick(1);
      chk("door_done_clear", 32'(bus.door_done), 0);
      chk("door_limit_quiet", 32'(bus.limit_err), 0);
      chk("door_floor", 32'(bus.floor), 7);

      // fault in cycle 2 of a downward step
      set_code(2'b10);
      tick(1);
      set_code(2'b00);
      tick(1);
      chk("pre_fault_motor_down", 32'(bus.motor_down), 1);
      bus.erro = 1'b1;
      tick(1);
      chk("fault_motor_down", 32'(bus.motor_down), 0);
      chk("fault_flag", 32'(bus.fault), 1);
      chk("fault_door_open", 32'(bus.door_open), 1);
      chk("fault_floor", 32'(bus.floor), 7);
      bus.fault_clr = 1'b1;
      tick(1);
      chk("fault_clr_blocked", 32'(bus.fault), 1);
      chk("fault_clr_blocked_door", 32'(bus.door_open), 1);
`ifdef FLOOR_7SEG_EN
      chk("fault_seg_n", 32'(bus.seg_n), 32'h06);
`endif
      bus.erro = 1'b0;
      tick(1);
      bus.fault_clr = 1'b0;
      chk("fault_cleared", 32'(bus.fault), 0);
      chk("fault_cleared_door", 32'(bus.door_open), 0);
      chk("fault_cleared_floor", 32'(bus.floor), 7);

      // normal motion resumes after clear
      bus.target_floor = 3'd6;
      set_code(2'b10);
      tick(1);
      set_code(2'b00);
      tick(4);
      chk("resume_floor_6", 32'(bus.floor), 6);
      chk("resume_at_target", 32'(bus.at_target), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
